text_console_writer: RTL and testbench

//   Character-stream front end for the 80x25 text display: accepts one byte per handshake,

---
 rtl/text_console_writer.sv | 190 +++++++++++++++++++
 tb/tb_text_console_writer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/text_console_writer.sv
// Character-stream writer for an 80x25 text RAM: cursor tracking, word packing with a row
// shadow, control codes (BS/LF/CR/FF), auto-wrap and full/row clears.
module text_console_writer #(
  parameter int         COLS      = 80,
  parameter int         ROWS      = 25,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic [7:0]  char_data,
  output logic [8:0]  write_address,
  output logic [31:0] write_data,
  output logic        write_en,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);
  localparam int WPR   = COLS / 4;
  localparam int TOTAL = COLS * ROWS / 4;
  localparam logic [31:0]        FILL_W   = {4{FILL_CHAR}};
  localparam logic [WPR*32-1:0]  FILL_ROW = {WPR{FILL_W}};
  localparam logic [8:0]         LAST_CLR = 9'(TOTAL - 1);
  localparam logic [8:0]         LAST_RW  = 9'(WPR - 1);
  localparam logic [6:0]         LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]         LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WRITE, S_ROWCLR} state_t;

  state_t r_state, n_state;
  logic [8:0]  r_cnt, n_cnt;
  logic [6:0]  r_col, n_col;
  logic [4:0]  r_row, n_row;
  logic        r_wrap, n_wrap;
  logic [WPR-1:0][3:0][7:0] r_shadow, n_shadow;
  logic        r_we, n_we, r_ready, n_ready, r_busy, n_busy;
  logic [8:0]  r_addr, n_addr;
  logic [31:0] r_data, n_data;

  logic        w_acc, w_print;
  logic [4:0]  w_word;
  logic [6:0]  w_bcol;
  logic [4:0]  w_nrow;
  logic [8:0]  w_base;

  assign w_acc   = char_valid & r_ready;
  assign w_print = (char_data >= 8'h20) && (char_data <= 8'h7E);
  assign w_word  = r_col[6:2];
  assign w_bcol  = r_col - 7'd1;
  assign w_nrow  = (r_row == LAST_ROW) ? 5'd0 : r_row + 5'd1;
  assign w_base  = 9'(r_row) * 9'(WPR);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_CLEAR;
      r_cnt    <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_wrap   <= 1'b0;
      r_shadow <= FILL_ROW;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b1;
    end else begin
      r_state  <= n_state;
      r_cnt    <= n_cnt;
      r_col    <= n_col;
      r_row    <= n_row;
      r_wrap   <= n_wrap;
      r_shadow <= n_shadow;
      r_we     <= n_we;
      r_addr   <= n_addr;
      r_data   <= n_data;
      r_ready  <= n_ready;
      r_busy   <= n_busy;
    end
  end

  always_comb begin
    n_state  = r_state;
    n_cnt    = r_cnt;
    n_col    = r_col;
    n_row    = r_row;
    n_wrap   = r_wrap;
    n_shadow = r_shadow;
    n_we     = 1'b0;
    n_addr   = r_addr;
    n_data   = r_data;
    case (r_state)
      S_CLEAR: begin
        n_we   = 1'b1;
        n_addr = r_cnt;
        n_data = FILL_W;
        if (r_cnt == LAST_CLR) begin
          n_state = S_IDLE;
          n_cnt   = '0;
          n_col   = '0;
          n_row   = '0;
        end else begin
          n_cnt = r_cnt + 9'd1;
        end
      end
      S_IDLE: begin
        if (w_acc) begin
          if (w_print) begin
            n_shadow[w_word][r_col[1:0]] = char_data;
            n_we    = 1'b1;
            n_addr  = w_base + 9'(w_word);
            n_data  = n_shadow[w_word];
            n_state = S_WRITE;
            // Last column: the word write goes out first, then the next row is cleared
            if (r_col == LAST_COL) begin
              n_col  = '0;
              n_row  = w_nrow;
              n_wrap = 1'b1;
            end else begin
              n_col  = r_col + 7'd1;
              n_wrap = 1'b0;
            end
          end else begin
            case (char_data)
              8'h08: begin
                if (r_col != 7'd0) begin
                  n_col = w_bcol;
                  n_shadow[w_bcol[6:2]][w_bcol[1:0]] = FILL_CHAR;
                  n_we    = 1'b1;
                  n_addr  = w_base + 9'(w_bcol[6:2]);
                  n_data  = n_shadow[w_bcol[6:2]];
                  n_wrap  = 1'b0;
                  n_state = S_WRITE;
                end
              end
              8'h0A: begin
                n_col    = '0;
                n_row    = w_nrow;
                n_cnt    = '0;
                n_shadow = FILL_ROW;
                n_state  = S_ROWCLR;
              end
              8'h0D: n_col = '0;
              8'h0C: begin
                n_col    = '0;
                n_row    = '0;
                n_cnt    = '0;
                n_shadow = FILL_ROW;
                n_state  = S_CLEAR;
              end
              default: ;
            endcase
          end
        end
      end
      S_WRITE: begin
        if (r_wrap) begin
          n_state  = S_ROWCLR;
          n_cnt    = '0;
          n_shadow = FILL_ROW;
          n_wrap   = 1'b0;
        end else begin
          n_state = S_IDLE;
        end
      end
      S_ROWCLR: begin
        n_we   = 1'b1;
        n_addr = w_base + r_cnt;
        n_data = FILL_W;
        if (r_cnt == LAST_RW) begin
          n_state = S_IDLE;
          n_cnt   = '0;
        end else begin
          n_cnt = r_cnt + 9'd1;
        end
      end
      default: n_state = S_CLEAR;
    endcase
    n_ready = (n_state == S_IDLE);
    n_busy  = ~n_ready;
  end

  assign char_ready    = r_ready;
  assign busy          = r_busy;
  assign write_en      = r_we;
  assign write_address = r_addr;
  assign write_data    = r_data;
  assign cursor_col    = r_col;
  assign cursor_row    = r_row;
endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: vector table for single-char effects plus
// sequences for reset clear, wrap, row wrap-around, FF with held valid and mid-clear reset.
module tb_text_console_writer;
  logic        clk = 1'b0, resetn = 1'b0, char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        char_ready, write_en, busy;
  logic [8:0]  write_address;
  logic [31:0] write_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;

  localparam logic [31:0] SP = 32'h20202020;

  text_console_writer dut (
    .clk(clk), .resetn(resetn), .char_valid(char_valid), .char_ready(char_ready),
    .char_data(char_data), .write_address(write_address), .write_data(write_data),
    .write_en(write_en), .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [8:0] a; logic [31:0] d; int c; } wr_t;
  wr_t q[$];
  always @(negedge clk) if (write_en) q.push_back('{write_address, write_data, cyc});

  int total = 0, bad = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Counts ascending clear-write errors over the first n queued writes
  function automatic int clr_err(input int n);
    int e = 0;
    for (int i = 0; i < n; i++)
      if (q[i].a != 9'(i) || q[i].d != SP || q[i].c != q[0].c + i) e++;
    return e;
  endfunction

  task automatic wait_idle(output int lo);
    int n = 0;
    lo = 0;
    while (!(char_ready && !busy) && n < 3000) begin
      lo++;
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", 32'(n < 3000), 32'd1);
    @(negedge clk); #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!char_ready && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("ready_timeout", 32'(n < 3000), 32'd1);
  endtask

  task automatic send(input logic [7:0] c, output int lo);
    wait_ready();
    char_data  = c;
    char_valid = 1'b1;
    @(posedge clk); #1;
    char_valid = 1'b0;
    wait_idle(lo);
  endtask

  typedef struct { logic [7:0] ch; int nw; logic [8:0] a; logic [31:0] d; int col; int row; int lo; } vec_t;
  vec_t vt[13];

  initial begin
    int lo, n;
    vt[0]  = '{8'h41, 1, 9'd0,  32'h20202041, 1, 0, 1};
    vt[1]  = '{8'h42, 1, 9'd0,  32'h20204241, 2, 0, 1};
    vt[2]  = '{8'h43, 1, 9'd0,  32'h20434241, 3, 0, 1};
    vt[3]  = '{8'h44, 1, 9'd0,  32'h44434241, 4, 0, 1};
    vt[4]  = '{8'h45, 1, 9'd1,  32'h20202045, 5, 0, 1};
    vt[5]  = '{8'h08, 1, 9'd1,  32'h20202020, 4, 0, 1};
    vt[6]  = '{8'h0D, 0, 9'd0,  32'h0,        0, 0, 0};
    vt[7]  = '{8'h08, 0, 9'd0,  32'h0,        0, 0, 0};
    vt[8]  = '{8'h07, 0, 9'd0,  32'h0,        0, 0, 0};
    vt[9]  = '{8'hFF, 0, 9'd0,  32'h0,        0, 0, 0};
    vt[10] = '{8'h5A, 1, 9'd0,  32'h4443425A, 1, 0, 1};
    vt[11] = '{8'h0A, 20, 9'd39, SP,          0, 1, 20};
    vt[12] = '{8'h51, 1, 9'd20, 32'h20202051, 1, 1, 1};

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_we", 32'(write_en), 32'd0);
    chk("rst_ready", 32'(char_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_addr", 32'(write_address), 32'd0);
    chk("rst_data", write_data, 32'd0);
    chk("rst_cur", 32'({cursor_col, cursor_row}), 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    wait_idle(lo);
    chk("init_cnt", 32'(q.size()), 32'd500);
    chk("init_seq", 32'(clr_err(q.size())), 32'd0);
    chk("init_ready", 32'(char_ready), 32'd1);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_cur", 32'({cursor_col, cursor_row}), 32'd0);

    // vector table
    for (int i = 0; i < 13; i++) begin
      q.delete();
      send(vt[i].ch, lo);
      chk($sformatf("v%0d_nw", i), 32'(q.size()), 32'(vt[i].nw));
      if (vt[i].nw > 0 && q.size() > 0) begin
        chk($sformatf("v%0d_addr", i), 32'(q[$].a), 32'(vt[i].a));
        chk($sformatf("v%0d_data", i), q[$].d, vt[i].d);
      end
      chk($sformatf("v%0d_col", i), 32'(cursor_col), 32'(vt[i].col));
      chk($sformatf("v%0d_row", i), 32'(cursor_row), 32'(vt[i].row));
      chk($sformatf("v%0d_lo", i), 32'(lo), 32'(vt[i].lo));
    end

    // LF from last row wraps to row 0 and clears it
    for (int i = 0; i < 23; i++) send(8'h0A, lo);
    chk("row24", 32'(cursor_row), 32'd24);
    q.delete();
    send(8'h0A, lo);
    chk("lfw_cnt", 32'(q.size()), 32'd20);
    if (q.size() == 20) begin
      chk("lfw_first", 32'(q[0].a), 32'd0);
      chk("lfw_last", 32'(q[19].a), 32'd19);
      chk("lfw_data", q[19].d, SP);
    end
    chk("lfw_cur", 32'({cursor_col, cursor_row}), 32'd0);
    q.delete();
    send(8'h4D, lo);
    chk("lfw_M", q.size() > 0 ? q[0].d : 32'hX, 32'h2020204D);

    // FF with valid held high; next char queued behind the clear
    wait_ready();
    q.delete();
    char_data = 8'h0C; char_valid = 1'b1;
    @(posedge clk); #1;
    char_data = 8'h50;
    n = 0;
    while (q.size() < 501 && n < 3000) begin @(negedge clk); #1; n++; end
    char_valid = 1'b0;
    chk("ff_cnt", 32'(q.size()), 32'd501);
    if (q.size() >= 501) begin
      chk("ff_seq", 32'(clr_err(500)), 32'd0);
      chk("ff_P_addr", 32'(q[500].a), 32'd0);
      chk("ff_P_data", q[500].d, 32'h20202050);
    end
    wait_idle(lo);
    chk("ff_cur", 32'({cursor_col, cursor_row}), {25'd0, 7'd1, 5'd0} >> 0);

    // 80 chars on row 0 -> wrap and clear of row 1
    send(8'h0D, lo);
    q.delete();
    for (int i = 0; i < 80; i++) send(8'h78, lo);
    chk("wrap_cnt", 32'(q.size()), 32'd100);
    if (q.size() == 100) begin
      chk("wrap_w0", q[3].d, 32'h78787878);
      chk("wrap_last_a", 32'(q[79].a), 32'd19);
      chk("wrap_last_d", q[79].d, 32'h78787878);
      chk("wrap_rc_first", 32'(q[80].a), 32'd20);
      chk("wrap_rc_last", 32'(q[99].a), 32'd39);
      chk("wrap_rc_data", q[99].d, SP);
    end
    chk("wrap_lo", 32'(lo), 32'd21);
    chk("wrap_cur", 32'({cursor_col, cursor_row}), 32'd1);

    // reset pulse mid-clear restarts from address 0
    wait_ready();
    q.delete();
    char_data = 8'h0C; char_valid = 1'b1;
    @(posedge clk); #1;
    char_valid = 1'b0;
    n = 0;
    while (!(q.size() > 0 && q[$].a == 9'd250) && n < 3000) begin @(negedge clk); #1; n++; end
    chk("mid_reach250", 32'(n < 3000), 32'd1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_we", 32'(write_en), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd1);
    @(negedge clk); #1;
    q.delete();
    resetn = 1'b1;
    @(posedge clk); #1;
    wait_idle(lo);
    chk("mid_cnt", 32'(q.size()), 32'd500);
    chk("mid_seq", 32'(clr_err(q.size())), 32'd0);
    chk("mid_cur", 32'({cursor_col, cursor_row}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
